// File: rtl/role_loader_if.sv
// Role loader bus: start/next controls, seed ROM port and the role reveal outputs.
interface role_loader_if;
   logic       start;
   logic       next;
   logic [4:0] rom_address;
   logic [9:0] rom_data;
   logic [9:0] roles;
   logic [2:0] wolf_id;
   logic [2:0] doctor_id;
   logic [2:0] reveal_player;
   logic [1:0] reveal_role;
   logic       reveal_valid;
   logic       done;
   logic       error;

   modport master (
      output start, next, rom_data,
      input  rom_address, roles, wolf_id, doctor_id, reveal_player,
      input  reveal_role, reveal_valid, done, error
   );

   modport slave (
      input  start, next, rom_data,
      output rom_address, roles, wolf_id, doctor_id, reveal_player,
      output reveal_role, reveal_valid, done, error
   );
endinterface

// File: rtl/role_loader.sv
// Draws a 5-player role word from a seed ROM, locates wolf/doctor and reveals roles one player at a time.
// Build macro ROLE_CHECK_EN enables ROM word validation; invalid words then land in ERROR.
module role_loader #(
   parameter int NUM_SEEDS = 20
) (
   input logic          clock,
   input logic          reset,
   role_loader_if.slave bus
);
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_WAIT   = 3'd2;
   localparam logic [2:0] ST_LOAD   = 3'd3;
   localparam logic [2:0] ST_CHECK  = 3'd4;
   localparam logic [2:0] ST_REVEAL = 3'd5;
   localparam logic [2:0] ST_DONE   = 3'd6;
   localparam logic [2:0] ST_ERROR  = 3'd7;

   localparam logic [4:0] SEED_LAST   = 5'(NUM_SEEDS - 1);
   localparam logic [2:0] NO_PLAYER   = 3'd7;
   localparam logic [2:0] LAST_PLAYER = 3'd4;
   localparam logic [1:0] ROLE_WOLF   = 2'b01;
   localparam logic [1:0] ROLE_DOCTOR = 2'b10;
   localparam logic [1:0] ROLE_BAD    = 2'b11;

   // Player 0 occupies the top field of the word
   function automatic logic [1:0] field_of(input logic [9:0] word, input logic [2:0] idx);
      case (idx)
         3'd0:    field_of = word[9:8];
         3'd1:    field_of = word[7:6];
         3'd2:    field_of = word[5:4];
         3'd3:    field_of = word[3:2];
         3'd4:    field_of = word[1:0];
         default: field_of = 2'b00;
      endcase
   endfunction

   function automatic logic [2:0] lowest_index(input logic [9:0] word, input logic [1:0] code);
      lowest_index = NO_PLAYER;
      for (int i = 4; i >= 0; i--) begin
         if (field_of(word, 3'(i)) == code) lowest_index = 3'(i);
      end
   endfunction

   function automatic logic [2:0] count_role(input logic [9:0] word, input logic [1:0] code);
      count_role = 3'd0;
      for (int i = 0; i < 5; i++) begin
         if (field_of(word, 3'(i)) == code) count_role = count_role + 3'd1;
      end
   endfunction

   logic [2:0] state_r, state_nx_s;
   logic [4:0] seed_r;
   logic [4:0] rom_address_r;
   logic [9:0] roles_r;
   logic [2:0] wolf_r, doctor_r, player_r;
   logic       valid_r, done_r, error_r;
   logic       capture_s, word_ok_s;

   // Decide whether the latched word may be revealed
   always_comb begin
`ifdef ROLE_CHECK_EN
      word_ok_s = (count_role(roles_r, ROLE_BAD) == 3'd0) &&
                  (count_role(roles_r, ROLE_WOLF) == 3'd1) &&
                  (count_role(roles_r, ROLE_DOCTOR) == 3'd1);
`else
      word_ok_s = 1'b1;
`endif
   end

   // Next-state logic; start is only honoured while idle, done or in error
   always_comb begin
      state_nx_s = state_r;
      capture_s  = 1'b0;
      case (state_r)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (bus.start) begin
               capture_s  = 1'b1;
               state_nx_s = ST_FETCH;
            end else begin
               state_nx_s = state_r;
            end
         end
         ST_FETCH: state_nx_s = ST_WAIT;
         ST_WAIT:  state_nx_s = ST_LOAD;
         ST_LOAD:  state_nx_s = ST_CHECK;
         ST_CHECK: begin
            if (word_ok_s) state_nx_s = ST_REVEAL;
            else           state_nx_s = ST_ERROR;
         end
         ST_REVEAL: begin
            if (bus.next && (player_r == LAST_PLAYER)) state_nx_s = ST_DONE;
            else                                       state_nx_s = state_r;
         end
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // Free-running seed counter
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         seed_r <= 5'd0;
      end else if (seed_r == SEED_LAST) begin
         seed_r <= 5'd0;
      end else begin
         seed_r <= seed_r + 5'd1;
      end
   end

   // State register and status flags registered from the next state
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         valid_r <= 1'b0;
         done_r  <= 1'b0;
         error_r <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         valid_r <= (state_nx_s == ST_REVEAL);
         done_r  <= (state_nx_s == ST_DONE);
`ifdef ROLE_CHECK_EN
         error_r <= (state_nx_s == ST_ERROR);
`else
         error_r <= 1'b0;
`endif
      end
   end

   // Draw datapath: seed capture, role latch, wolf/doctor search and reveal index
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rom_address_r <= 5'd0;
         roles_r       <= 10'd0;
         wolf_r        <= NO_PLAYER;
         doctor_r      <= NO_PLAYER;
         player_r      <= 3'd0;
      end else begin
         if (capture_s) rom_address_r <= seed_r;
         if (state_r == ST_LOAD) roles_r <= bus.rom_data;
         if (state_r == ST_CHECK) begin
            wolf_r   <= lowest_index(roles_r, ROLE_WOLF);
            doctor_r <= lowest_index(roles_r, ROLE_DOCTOR);
            player_r <= 3'd0;
         end
         if ((state_r == ST_REVEAL) && bus.next && (player_r != LAST_PLAYER)) begin
            player_r <= player_r + 3'd1;
         end
      end
   end

   assign bus.rom_address   = rom_address_r;
   assign bus.roles         = roles_r;
   assign bus.wolf_id       = wolf_r;
   assign bus.doctor_id     = doctor_r;
   assign bus.reveal_player = player_r;
   assign bus.reveal_role   = field_of(roles_r, player_r);
   assign bus.reveal_valid  = valid_r;
   assign bus.done          = done_r;
   assign bus.error         = error_r;
endmodule
